// File: rtl/seq_pkg.sv
// Shared types and constants for the serial framer.
// Holds the FSM state encoding and the sync field definition.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF
  } state_t;

  localparam logic [3:0] SYNC_PATTERN = 4'b0001;
  localparam int         SYNC_LEN     = 4;
  localparam int         RUN_MAX_DEF  = 2;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register for the payload word.
// Shifting pauses whenever shift is low, e.g. during a stuffed bit.
module seq_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              msb
);

  logic [DATA_W-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = q[DATA_W-1];

endmodule

// File: rtl/seq_framer_tx.sv
// Serial frame transmitter: sync field, MSB-first payload, zero-run
// bit stuffing. dout always shows the bit chosen on the previous edge.
module seq_framer_tx
  import seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RUN_MAX = RUN_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              start,
  output logic              ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int RW = $clog2(RUN_MAX + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [RW-1:0] run_q, run_d;
  logic [1:0]    sidx_q, sidx_d;
  logic [1:0]    sidx_nx;
  logic          dout_d, valid_d, done_d;
  logic          load, shift, msb, emit;
  logic [CW-1:0] pay_cnt;
  logic [RW-1:0] pay_run;
  logic          pay_done;

  seq_piso #(
    .DATA_W(DATA_W)
  ) u_piso (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .shift(shift),
    .d    (din),
    .msb  (msb)
  );

  // Counters as they would stand after emitting the next payload bit.
  assign pay_cnt  = bcnt_q + 1'b1;
  assign pay_run  = msb ? '0 : run_q + 1'b1;
  assign pay_done = (pay_cnt == CW'(DATA_W))
                 && (pay_run != RW'(RUN_MAX));
  assign sidx_nx  = sidx_q + 2'd1;
  assign ready    = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    run_d   = run_q;
    sidx_d  = sidx_q;
    dout_d  = 1'b1;
    valid_d = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    emit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SYNC;
          sidx_d  = 2'd0;
          bcnt_d  = '0;
          run_d   = '0;
          dout_d  = SYNC_PATTERN[SYNC_LEN-1];
          valid_d = 1'b1;
        end
      end
      SYNC: begin
        if (sidx_q == 2'(SYNC_LEN - 1)) begin
          emit = 1'b1;
        end else begin
          sidx_d  = sidx_nx;
          dout_d  = SYNC_PATTERN[~sidx_nx];
          valid_d = 1'b1;
        end
      end
      DATA: begin
        if (run_q == RW'(RUN_MAX)) begin
          state_d = STUFF;
          run_d   = '0;
          valid_d = 1'b1;
          done_d  = (bcnt_q == CW'(DATA_W));
        end else if (bcnt_q == CW'(DATA_W)) begin
          state_d = IDLE;
        end else begin
          emit = 1'b1;
        end
      end
      STUFF: begin
        if (bcnt_q == CW'(DATA_W)) begin
          state_d = IDLE;
        end else begin
          emit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      state_d = DATA;
      dout_d  = msb;
      valid_d = 1'b1;
      shift   = 1'b1;
      bcnt_d  = pay_cnt;
      run_d   = pay_run;
      done_d  = pay_done;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bcnt_q     <= '0;
      run_q      <= '0;
      sidx_q     <= '0;
      dout       <= 1'b1;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      run_q      <= run_d;
      sidx_q     <= sidx_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_framer_tx.sv
// Directed vector bench for seq_framer_tx.
// Frames are compared bit by bit against hand-computed patterns.
module tb_seq_framer_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       start;
  logic       ready, dout, dout_valid, done;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [7:0]  din;
    int          len;
    logic [15:0] bits;
  } vec_t;

  vec_t tbl[7];
  vec_t v;

  seq_framer_tx #(
    .DATA_W (8),
    .RUN_MAX(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .start     (start),
    .ready     (ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at the negedge where the first sync bit is on dout.
  // Returns at the negedge of the idle cycle after the frame.
  task automatic check_frame(input vec_t f, input bit pulse);
    int zrun = 0;
    for (int i = 0; i < f.len; i++) begin
      chk($sformatf("bit%0d_din%h", i, f.din),
          {29'd0, dout, dout_valid, done},
          {29'd0, f.bits[15-i], 1'b1, i == f.len - 1});
      if (i >= 4) begin
        zrun = dout ? 0 : zrun + 1;
        chk($sformatf("zrun%0d_din%h", i, f.din),
            32'(zrun < 3), 32'd1);
      end
      if (pulse) start = (i < 3);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string name);
    chk(name, {28'd0, dout, dout_valid, done, ready}, 32'h9);
  endtask

  initial begin
    tbl[0] = '{8'hFF, 12, 16'h1FF0};
    tbl[1] = '{8'h00, 16, 16'h1249};
    tbl[2] = '{8'hA4, 14, 16'h1A64};
    tbl[3] = '{8'h55, 12, 16'h1550};
    tbl[4] = '{8'h33, 14, 16'h139C};
    tbl[5] = '{8'h01, 15, 16'h124A};
    tbl[6] = '{8'h80, 15, 16'h1924};

    reset = 1'b1;
    start = 1'b1;
    din   = 8'h00;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("post_reset_idle");

    for (int k = 0; k < 7; k++) begin
      chk($sformatf("ready_pre_%0d", k), 32'(ready), 32'd1);
      din   = tbl[k].din;
      start = 1'b1;
      @(negedge clk);
      din = ~tbl[k].din;
      check_frame(tbl[k], 1'b1);
      check_idle($sformatf("idle_after_%0d", k));
    end

    // Reset on payload bit 3, with start also high.
    din   = 8'hA4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("pre_abort_bit%0d", i),
          {30'd0, dout, dout_valid}, {30'd0, tbl[2].bits[15-i], 1'b1});
      if (i < 6) @(negedge clk);
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_idle("abort_idle");
    reset = 1'b0;
    start = 1'b1;
    din   = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check_frame(tbl[0], 1'b0);
    check_idle("idle_after_abort_frame");

    // start held high: 0x55 then 0x33 with one idle cycle between.
    din   = 8'h55;
    start = 1'b1;
    @(negedge clk);
    din = 8'h33;
    check_frame(tbl[3], 1'b0);
    check_idle("b2b_gap");
    @(negedge clk);
    v = tbl[4];
    check_frame(v, 1'b1);
    check_idle("b2b_end");
    @(negedge clk);
    check_idle("b2b_stays_idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/seq_framer_tx.md
SEQ_FRAMER_TX -- requirements
Module: seq_framer_tx

Interface
REQ-001 Parameter: DATA_W, 8, payload width in bits (>= 2).
REQ-002 Parameter: RUN_MAX, 2, payload zero-run length that forces a stuffed '1'.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: din  input  DATA_W  payload word, sampled on accept.
REQ-007 Port: start  input  1  request to send din.
REQ-008 Port: ready  output  1  high only in IDLE; start && ready = accept.
REQ-009 Port: dout  output  1  serial line, registered, idle level '1'.
REQ-010 Port: dout_valid  output  1  high while a frame bit (sync, payload or stuff) is on dout.
REQ-011 Port: done  output  1  one-cycle pulse, coincident with the last bit of a frame.

Function
REQ-012 Frame format SHALL be: sync 0,0,0,1, then payload MSB first, with stuffed '1' bits.
REQ-013 The block SHALL insert one stuffed '1' immediately after every RUN_MAX consecutive payload zeros, including after the final payload bit.
REQ-014 The zero-run count SHALL clear on any '1' sent (payload or stuffed) and at frame start; sync bits SHALL NOT count.
REQ-015 Frame length SHALL be 4 + DATA_W + stuff count: 12..16 cycles for DATA_W=8.
REQ-016 FSM states SHALL be IDLE, SYNC, DATA, STUFF.
REQ-017 IDLE: ready=1, dout=1, dout_valid=0; on accept, latch din and go to SYNC.
REQ-018 SYNC: drive the 4 sync bits over 4 cycles, then go to DATA.
REQ-019 DATA: drive one payload bit per cycle; go to STUFF when the run reaches RUN_MAX; after the last bit with no stuff due, go to IDLE.
REQ-020 STUFF: drive '1' for one cycle; return to DATA if payload bits remain, otherwise go to IDLE.
REQ-021 Latency: the first sync bit SHALL appear on dout the cycle after the accept edge.
REQ-022 start while ready=0 SHALL be ignored; din changes after accept SHALL NOT affect the frame.
REQ-023 Back-to-back: at least one IDLE cycle (dout=1) SHALL separate frames; with start held high, the gap SHALL be exactly one cycle.
REQ-024 done SHALL assert on the cycle the final frame bit (payload or trailing stuff) is on dout, and at no other time.
REQ-025 No three consecutive zeros SHALL appear on dout outside the sync field.

Reset
REQ-026 While reset is high at a clock edge: state=IDLE, dout=1, ready=1, dout_valid=0, done=0, shift register and counters=0.
REQ-027 Reset mid-frame SHALL abort the frame with no done pulse; the next accept is possible in the first cycle after reset deasserts.
REQ-028 reset SHALL take priority over start in the same cycle.

Structure
REQ-029 Shared package seq_pkg SHALL hold the state enum, SYNC_PATTERN=4'b0001, SYNC_LEN=4 and the default RUN_MAX.
REQ-030 One sub-module, seq_piso, SHALL provide the parallel-load, MSB-first shift register with a shift-enable that is held during STUFF.
REQ-031 The FSM, bit counter and zero-run counter SHALL live in seq_framer_tx.

Verification
REQ-032 din=8'hFF accepted -> dout 0001 11111111 (12 bits), done on bit 12, ready=1 the next cycle.
REQ-033 din=8'h00 -> dout 0001 001 001 001 001 (16 bits), done on the trailing stuff bit.
REQ-034 din=8'hA4 -> dout 0001 1 0 1 0 0 1 1 0 0 1 (14 bits); check REQ-025 on every frame.
REQ-035 start held high with din=8'h55, then 8'h33 -> two frames separated by exactly one dout=1 idle cycle; start pulses during a frame are ignored.
REQ-036 reset asserted at payload bit 3 of a frame -> next cycle dout=1, ready=1, no done; a new accept then yields a clean frame.
